// File: rtl/fpu_arbiter.sv
// Round-robin arbiter sharing one multi-cycle FPU between two requesters.
// Latches the winning op, holds FPU inputs for the op latency, returns the result.
module fpu_arbiter #(
  parameter int LAT_ADD  = 3,
  parameter int LAT_MUL  = 3,
  parameter int LAT_DIV  = 11,
  parameter int LAT_SQRT = 8,
  parameter int LAT_CVT  = 1,
  parameter int CNT_W    = 4
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [1:0]  req_valid,
  output logic [1:0]  req_ready,
  input  logic [7:0]  req_op,
  input  logic [63:0] req_src0,
  input  logic [63:0] req_src1,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic        rsp_id,
  output logic        busy,
  output logic [31:0] fpu_src0,
  output logic [31:0] fpu_src1,
  output logic [3:0]  fpu_op,
  input  logic [31:0] fpu_result
);

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  localparam logic [CNT_W-1:0] L_ADD  = CNT_W'(LAT_ADD);
  localparam logic [CNT_W-1:0] L_MUL  = CNT_W'(LAT_MUL);
  localparam logic [CNT_W-1:0] L_DIV  = CNT_W'(LAT_DIV);
  localparam logic [CNT_W-1:0] L_SQRT = CNT_W'(LAT_SQRT);
  localparam logic [CNT_W-1:0] L_CVT  = CNT_W'(LAT_CVT);

  state_t            state;
  logic              rr_ptr;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  lat;
  logic [3:0]        op_q;
  logic [31:0]       src0_q;
  logic [31:0]       src1_q;
  logic [1:0]        grant;
  logic              win;

  always_comb begin
    grant = '0;
    if (state == IDLE) begin
      if (req_valid[rr_ptr])
        grant[rr_ptr] = 1'b1;
      else if (req_valid[~rr_ptr])
        grant[~rr_ptr] = 1'b1;
    end
  end

  assign win = grant[1];

  // ready is forced low while reset is held so nothing handshakes into reset
  assign req_ready = rstn ? grant : 2'b00;

  always_comb begin
    lat = '0;
    unique case (op_q)
      4'b0000, 4'b0001: lat = L_ADD;
      4'b0010:          lat = L_MUL;
      4'b0011:          lat = L_DIV;
      4'b0100:          lat = L_SQRT;
      4'b1011, 4'b1100: lat = L_CVT;
      default:          lat = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= IDLE;
      rr_ptr   <= 1'b0;
      cnt      <= '0;
      op_q     <= 4'hF;
      src0_q   <= '0;
      src1_q   <= '0;
      rsp_data <= '0;
      rsp_id   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (|grant) begin
            op_q   <= req_op[{win, 2'b00} +: 4];
            src0_q <= req_src0[{win, 5'b00000} +: 32];
            src1_q <= req_src1[{win, 5'b00000} +: 32];
            rsp_id <= win;
            rr_ptr <= ~win;
            cnt    <= '0;
            state  <= EXEC;
          end
        end
        EXEC: begin
          if (cnt == lat) begin
            rsp_data <= fpu_result;
            state    <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          if (rsp_ready)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // outside EXEC the FPU sees the idle opcode so its counter stays at 0
  assign fpu_op    = (state == EXEC) ? op_q : 4'hF;
  assign fpu_src0  = src0_q;
  assign fpu_src1  = src1_q;
  assign rsp_valid = (state == DONE);
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_fpu_arbiter.sv
// Directed bench for fpu_arbiter with a small timed FPU model.
// The model returns a valid result only on the cycle its latency expires.
module tb_fpu_arbiter;

  logic        clk = 1'b0;
  logic        rstn;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [7:0]  req_op;
  logic [63:0] req_src0;
  logic [63:0] req_src1;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic        rsp_id;
  logic        busy;
  logic [31:0] fpu_src0;
  logic [31:0] fpu_src1;
  logic [3:0]  fpu_op;
  logic [31:0] fpu_result;

  int total = 0;
  int bad   = 0;

  fpu_arbiter dut (
    .clk        (clk),
    .rstn       (rstn),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_src0   (req_src0),
    .req_src1   (req_src1),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_data   (rsp_data),
    .rsp_id     (rsp_id),
    .busy       (busy),
    .fpu_src0   (fpu_src0),
    .fpu_src1   (fpu_src1),
    .fpu_op     (fpu_op),
    .fpu_result (fpu_result)
  );

  always #5 clk = ~clk;

  function automatic int m_lat(input logic [3:0] op);
    case (op)
      4'b0000, 4'b0001, 4'b0010: return 3;
      4'b0011:                   return 11;
      4'b0100:                   return 8;
      4'b1011, 4'b1100:          return 1;
      default:                   return 0;
    endcase
  endfunction

  function automatic logic [31:0] m_fn(input logic [3:0] op,
                                       input logic [31:0] a,
                                       input logic [31:0] b);
    case (op)
      4'b0000: if (a == 32'h3F800000 && b == 32'h40000000) return 32'h40400000;
      4'b0010: begin
        if (a == 32'h40000000 && b == 32'h40400000) return 32'h40C00000;
        if (a == 32'h40400000 && b == 32'h40800000) return 32'h41400000;
      end
      4'b0011: if (a == 32'h3F800000 && b == 32'h40800000) return 32'h3E800000;
      4'b0100: if (a == 32'h40800000) return 32'h40000000;
      4'b0110: return {~b[31], a[30:0]};
      4'b1000: return (a == b) ? 32'd1 : 32'd0;
      4'b1111: return 32'd0;
      default: ;
    endcase
    return 32'hDEADBEEF;
  endfunction

  logic [4:0] m_cnt;

  always @(posedge clk or negedge rstn) begin
    if (!rstn) m_cnt <= '0;
    else if (fpu_op == 4'hF) m_cnt <= '0;
    else m_cnt <= m_cnt + 5'd1;
  end

  always_comb begin
    if (int'(m_cnt) == m_lat(fpu_op))
      fpu_result = m_fn(fpu_op, fpu_src0, fpu_src1);
    else
      fpu_result = 32'hDEADBEEF;
  end

  // Called at a negedge; returns one #1 past the posedge that handshakes,
  // with the payload already scrambled and valid dropped.
  task automatic send(input int i, input logic [3:0] op,
                      input logic [31:0] a, input logic [31:0] b,
                      output bit ok);
    req_op[i*4 +: 4]    = op;
    req_src0[i*32 +: 32] = a;
    req_src1[i*32 +: 32] = b;
    req_valid[i]         = 1'b1;
    ok = 1'b0;
    for (int n = 0; n < 64 && !ok; n++) begin
      #1;
      if (req_ready[i]) ok = 1'b1;
      else @(negedge clk);
    end
    if (ok) begin
      @(posedge clk);
      #1;
      req_valid[i]         = 1'b0;
      req_op[i*4 +: 4]     = 4'b1001;
      req_src0[i*32 +: 32] = 32'hFFFFFFFF;
      req_src1[i*32 +: 32] = 32'hFFFFFFFF;
    end
  endtask

  // Counts cycles from the handshake cycle to the first rsp_valid cycle.
  task automatic await_rsp(output int lat);
    lat = 0;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (rsp_valid) begin
        lat = n;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rstn      = 1'b0;
    req_valid = 2'b11;
    req_op    = '0;
    req_src0  = '0;
    req_src1  = '0;
    rsp_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    total++;
    if ({req_ready, rsp_valid, rsp_id, busy, fpu_op} !== 9'b00_0_0_0_1111) begin
      bad++;
      $display("FAIL reset_ctrl got=%b exp=%b",
               {req_ready, rsp_valid, rsp_id, busy, fpu_op}, 9'b00_0_0_0_1111);
    end
    total++;
    if (rsp_data !== 32'd0) begin
      bad++;
      $display("FAIL reset_data got=%h exp=0", rsp_data);
    end
    total++;
    if ({fpu_src0, fpu_src1} !== 64'd0) begin
      bad++;
      $display("FAIL reset_src got=%h exp=0", {fpu_src0, fpu_src1});
    end
    req_valid = 2'b00;
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_round_robin;
    bit ok;
    int lat;
    for (int p = 0; p < 2; p++) begin
      @(negedge clk);
      req_op    = {4'b0010, 4'b0010};
      req_src0  = {32'h40400000, 32'h40000000};
      req_src1  = {32'h40800000, 32'h40400000};
      req_valid = 2'b11;
      #1;
      total++;
      if (req_ready !== 2'b01) begin
        bad++;
        $display("FAIL rr_grant0 pass=%0d got=%b exp=01", p, req_ready);
      end
      send(0, 4'b0010, 32'h40000000, 32'h40400000, ok);
      await_rsp(lat);
      total++;
      if (!ok || lat != 5 || rsp_data !== 32'h40C00000 || rsp_id !== 1'b0) begin
        bad++;
        $display("FAIL rr_rsp0 pass=%0d got ok=%0d lat=%0d data=%h id=%0d exp lat=5 data=40c00000 id=0",
                 p, ok, lat, rsp_data, rsp_id);
      end
      @(negedge clk);
      #1;
      total++;
      if (req_ready !== 2'b10) begin
        bad++;
        $display("FAIL rr_grant1 pass=%0d got=%b exp=10", p, req_ready);
      end
      send(1, 4'b0010, 32'h40400000, 32'h40800000, ok);
      await_rsp(lat);
      total++;
      if (!ok || lat != 5 || rsp_data !== 32'h41400000 || rsp_id !== 1'b1) begin
        bad++;
        $display("FAIL rr_rsp1 pass=%0d got ok=%0d lat=%0d data=%h id=%0d exp lat=5 data=41400000 id=1",
                 p, ok, lat, rsp_data, rsp_id);
      end
    end
  endtask

  task automatic test_single_fadd;
    bit ok;
    int lat;
    @(negedge clk);
    send(0, 4'b0000, 32'h3F800000, 32'h40000000, ok);
    total++;
    if (!ok || fpu_op !== 4'b0000 || fpu_src0 !== 32'h3F800000 || fpu_src1 !== 32'h40000000) begin
      bad++;
      $display("FAIL fadd_drive got ok=%0d op=%b s0=%h s1=%h exp op=0000 s0=3f800000 s1=40000000",
               ok, fpu_op, fpu_src0, fpu_src1);
    end
    await_rsp(lat);
    total++;
    if (lat != 5 || rsp_data !== 32'h40400000 || rsp_id !== 1'b0) begin
      bad++;
      $display("FAIL fadd_rsp got lat=%0d data=%h id=%0d exp lat=5 data=40400000 id=0",
               lat, rsp_data, rsp_id);
    end
  endtask

  task automatic test_fdiv_hold;
    bit ok;
    int lat;
    @(negedge clk);
    rsp_ready = 1'b0;
    send(1, 4'b0011, 32'h3F800000, 32'h40800000, ok);
    await_rsp(lat);
    total++;
    if (!ok || lat != 13 || rsp_data !== 32'h3E800000 || rsp_id !== 1'b1) begin
      bad++;
      $display("FAIL fdiv_rsp got ok=%0d lat=%0d data=%h id=%0d exp lat=13 data=3e800000 id=1",
               ok, lat, rsp_data, rsp_id);
    end
    req_op[3:0]    = 4'b0110;
    req_src0[31:0] = 32'h3F800000;
    req_src1[31:0] = 32'h3F800000;
    req_valid[0]   = 1'b1;
    for (int c = 0; c < 10; c++) begin
      #1;
      total++;
      if ({rsp_valid, rsp_id, rsp_data, req_ready} !== {1'b1, 1'b1, 32'h3E800000, 2'b00}) begin
        bad++;
        $display("FAIL fdiv_hold cyc=%0d got v=%0d id=%0d data=%h rdy=%b exp v=1 id=1 data=3e800000 rdy=00",
                 c, rsp_valid, rsp_id, rsp_data, req_ready);
      end
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    send(0, 4'b0110, 32'h3F800000, 32'h3F800000, ok);
    await_rsp(lat);
    total++;
    if (!ok || lat != 2 || rsp_data !== 32'hBF800000 || rsp_id !== 1'b0) begin
      bad++;
      $display("FAIL fsgnjn_rsp got ok=%0d lat=%0d data=%h id=%0d exp lat=2 data=bf800000 id=0",
               ok, lat, rsp_data, rsp_id);
    end
  endtask

  task automatic test_zero_lat;
    bit ok;
    int lat;
    @(negedge clk);
    send(1, 4'b1000, 32'h40000000, 32'h40000000, ok);
    await_rsp(lat);
    total++;
    if (!ok || lat != 2 || rsp_data !== 32'd1 || rsp_id !== 1'b1) begin
      bad++;
      $display("FAIL feq_rsp got ok=%0d lat=%0d data=%h id=%0d exp lat=2 data=1 id=1",
               ok, lat, rsp_data, rsp_id);
    end
    send(1, 4'b0110, 32'h3F800000, 32'hBF800000, ok);
    await_rsp(lat);
    total++;
    if (!ok || lat != 2 || rsp_data !== 32'h3F800000) begin
      bad++;
      $display("FAIL fsgnjn_pos got ok=%0d lat=%0d data=%h exp lat=2 data=3f800000",
               ok, lat, rsp_data);
    end
  endtask

  task automatic test_illegal;
    bit ok;
    int lat;
    @(negedge clk);
    send(0, 4'b1111, 32'h12345678, 32'h9ABCDEF0, ok);
    await_rsp(lat);
    total++;
    if (!ok || lat != 2 || rsp_data !== 32'd0 || rsp_id !== 1'b0) begin
      bad++;
      $display("FAIL illegal_rsp got ok=%0d lat=%0d data=%h id=%0d exp lat=2 data=0 id=0",
               ok, lat, rsp_data, rsp_id);
    end
    send(1, 4'b0000, 32'h3F800000, 32'h40000000, ok);
    await_rsp(lat);
    total++;
    if (!ok || lat != 5 || rsp_data !== 32'h40400000 || rsp_id !== 1'b1) begin
      bad++;
      $display("FAIL after_illegal got ok=%0d lat=%0d data=%h id=%0d exp lat=5 data=40400000 id=1",
               ok, lat, rsp_data, rsp_id);
    end
  endtask

  task automatic test_reset_mid;
    bit ok;
    bit seen;
    int lat;
    @(negedge clk);
    send(0, 4'b0100, 32'h40800000, 32'h00000000, ok);
    repeat (4) @(posedge clk);
    #2;
    total++;
    if (!ok || busy !== 1'b1 || fpu_op !== 4'b0100) begin
      bad++;
      $display("FAIL sqrt_exec got ok=%0d busy=%0d op=%b exp busy=1 op=0100", ok, busy, fpu_op);
    end
    rstn = 1'b0;
    #1;
    total++;
    if ({rsp_valid, busy, fpu_op, req_ready} !== {1'b0, 1'b0, 4'hF, 2'b00} || fpu_src0 !== 32'd0) begin
      bad++;
      $display("FAIL mid_reset got v=%0d busy=%0d op=%b rdy=%b s0=%h exp v=0 busy=0 op=1111 rdy=00 s0=0",
               rsp_valid, busy, fpu_op, req_ready, fpu_src0);
    end
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      if (rsp_valid || busy) seen = 1'b1;
    end
    total++;
    if (seen) begin
      bad++;
      $display("FAIL discard got rsp_or_busy=1 exp 0");
    end
    send(0, 4'b0000, 32'h3F800000, 32'h40000000, ok);
    await_rsp(lat);
    total++;
    if (!ok || lat != 5 || rsp_data !== 32'h40400000 || rsp_id !== 1'b0) begin
      bad++;
      $display("FAIL post_reset_fadd got ok=%0d lat=%0d data=%h id=%0d exp lat=5 data=40400000 id=0",
               ok, lat, rsp_data, rsp_id);
    end
  endtask

  initial begin
    test_reset;
    test_round_robin;
    test_single_fadd;
    test_fdiv_hold;
    test_zero_lat;
    test_illegal;
    test_reset_mid;
    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
